// File: rtl/propose_pkg.sv
// Shared types and helpers for the integer propose engine.
// LFSR constants, FSM encoding, accumulator sizing and clamping.
package propose_pkg;

    localparam int LFSR_WIDTH = 16;
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        REDUCE,
        SELECT,
        DONE
    } state_t;

    function automatic int acc_w(input int cw, input int viw);
        return 2 * cw + viw + 1;
    endfunction

    function automatic longint clamp(
        input longint x,
        input longint lo,
        input longint hi
    );
        if (x < lo) return lo;
        if (x > hi) return hi;
        return x;
    endfunction

    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(
        input logic [LFSR_WIDTH-1:0] s
    );
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/clause_bound_reduce.sv
// Reduces one clause against the assignment for variable v and
// classifies it as an upper bound, lower bound, no-op or error.
module clause_bound_reduce
    import propose_pkg::*;
#(
    parameter int COEF_WIDTH      = 8,
    parameter int VAR_INDEX_WIDTH = 2,
    parameter int VAR_MIN         = -(2**(COEF_WIDTH-1)),
    parameter int VAR_MAX         = 2**(COEF_WIDTH-1)-1
) (
    input  logic [(2**VAR_INDEX_WIDTH+1)*COEF_WIDTH-1:0] coefficients,
    input  logic [(2**VAR_INDEX_WIDTH)*COEF_WIDTH-1:0]   assignment,
    input  logic [VAR_INDEX_WIDTH-1:0]                   var_index,
    input  logic                                         enable,
    output logic signed [COEF_WIDTH-1:0]                 bound,
    output logic                                         is_upper,
    output logic                                         is_lower,
    output logic                                         error
);

    localparam int NUM_VARS = 2**VAR_INDEX_WIDTH;
    localparam int ACC_W    = acc_w(COEF_WIDTH, VAR_INDEX_WIDTH);

    logic signed [ACC_W-1:0]      r;
    logic signed [ACC_W-1:0]      b_acc;
    logic signed [COEF_WIDTH-1:0] a_k;
    logic signed [COEF_WIDTH-1:0] x_k;
    logic signed [COEF_WIDTH-1:0] b_k;
    logic signed [COEF_WIDTH-1:0] a_v;
    logic                         is_plus;
    logic                         is_minus;
    logic                         is_zero;

    always_comb begin
        b_k = coefficients[NUM_VARS*COEF_WIDTH +: COEF_WIDTH];
        r   = ACC_W'(b_k);
        a_v = '0;
        a_k = '0;
        x_k = '0;
        for (int k = 0; k < NUM_VARS; k++) begin
            a_k = coefficients[k*COEF_WIDTH +: COEF_WIDTH];
            x_k = assignment[k*COEF_WIDTH +: COEF_WIDTH];
            if (k == int'(var_index)) a_v = a_k;
            else r = r + ACC_W'(a_k) * ACC_W'(x_k);
        end

        is_plus  = (a_v == COEF_WIDTH'(1));
        is_minus = (a_v == {COEF_WIDTH{1'b1}});
        is_zero  = (a_v == '0);

        // a_v=+1 gives x_v <= -r, a_v=-1 gives x_v >= r
        b_acc = is_plus ? -r : r;
        bound = COEF_WIDTH'(clamp(longint'(b_acc),
                                  longint'(VAR_MIN),
                                  longint'(VAR_MAX)));

        is_upper = enable && is_plus;
        is_lower = enable && is_minus;
        error    = enable && !(is_plus || is_minus || is_zero);
    end

endmodule

// File: rtl/propose_integer_bounded_seq.sv
// Time-multiplexed integer propose engine, one clause per cycle.
// PROPOSE_STATS_EN enables the handshake/infeasible counters.
module propose_integer_bounded_seq
    import propose_pkg::*;
#(
    parameter int COEF_WIDTH         = 8,
    parameter int VAR_INDEX_WIDTH    = 2,
    parameter int CLAUSE_INDEX_WIDTH = 3,
    parameter int VAR_MIN            = -(2**(COEF_WIDTH-1)),
    parameter int VAR_MAX            = 2**(COEF_WIDTH-1)-1
) (
    input  logic                                         in_clk,
    input  logic                                         in_reset,
    input  logic [15:0]                                  in_seed,
    input  logic                                         in_load_valid,
    input  logic [CLAUSE_INDEX_WIDTH-1:0]                in_load_index,
    input  logic [(2**VAR_INDEX_WIDTH+1)*COEF_WIDTH-1:0] in_load_coefficients,
    input  logic                                         in_start,
    input  logic [VAR_INDEX_WIDTH-1:0]                   in_var_index,
    input  logic [(2**VAR_INDEX_WIDTH)*COEF_WIDTH-1:0]   in_assignment,
    input  logic [2**CLAUSE_INDEX_WIDTH-1:0]             in_clause_enable,
    input  logic                                         in_ready,
    output logic                                         out_busy,
    output logic                                         out_valid,
    output logic                                         out_feasible,
    output logic [COEF_WIDTH-1:0]                        out_lower,
    output logic [COEF_WIDTH-1:0]                        out_upper,
    output logic [COEF_WIDTH-1:0]                        out_value,
    output logic                                         out_error,
    output logic [15:0]                                  out_propose_count,
    output logic [15:0]                                  out_infeasible_count
);

    localparam int NUM_VARS    = 2**VAR_INDEX_WIDTH;
    localparam int NUM_CLAUSES = 2**CLAUSE_INDEX_WIDTH;
    localparam int CLAUSE_W    = (NUM_VARS+1)*COEF_WIDTH;
    localparam int ASSIGN_W    = NUM_VARS*COEF_WIDTH;
    localparam int PROD_W      = LFSR_WIDTH+COEF_WIDTH+1;
    localparam logic signed [COEF_WIDTH-1:0] LO_INIT = COEF_WIDTH'(VAR_MIN);
    localparam logic signed [COEF_WIDTH-1:0] HI_INIT = COEF_WIDTH'(VAR_MAX);

    state_t                        state;
    logic [CLAUSE_W-1:0]           bank [NUM_CLAUSES];
    logic [CLAUSE_INDEX_WIDTH-1:0] clause_idx;
    logic [VAR_INDEX_WIDTH-1:0]    var_q;
    logic [ASSIGN_W-1:0]           x_q;
    logic [NUM_CLAUSES-1:0]        mask_q;
    logic signed [COEF_WIDTH-1:0]  lo_q;
    logic signed [COEF_WIDTH-1:0]  hi_q;
    logic [LFSR_WIDTH-1:0]         lfsr;

    logic signed [COEF_WIDTH-1:0]  bound;
    logic                          is_upper;
    logic                          is_lower;
    logic                          clause_err;

    logic                          feasible;
    logic [COEF_WIDTH:0]           range_w;
    logic [COEF_WIDTH-1:0]         offset;
    logic [COEF_WIDTH-1:0]         pick;
    logic [COEF_WIDTH-1:0]         x_v;

    clause_bound_reduce #(
        .COEF_WIDTH      (COEF_WIDTH),
        .VAR_INDEX_WIDTH (VAR_INDEX_WIDTH),
        .VAR_MIN         (VAR_MIN),
        .VAR_MAX         (VAR_MAX)
    ) u_reduce (
        .coefficients (bank[clause_idx]),
        .assignment   (x_q),
        .var_index    (var_q),
        .enable       (mask_q[clause_idx]),
        .bound        (bound),
        .is_upper     (is_upper),
        .is_lower     (is_lower),
        .error        (clause_err)
    );

    // range is 1..2^COEF_WIDTH when feasible, so offset always lands in [lo,hi]
    always_comb begin
        feasible = (lo_q <= hi_q);
        range_w  = {hi_q[COEF_WIDTH-1], hi_q}
                 - {lo_q[COEF_WIDTH-1], lo_q}
                 + (COEF_WIDTH+1)'(1);
        offset   = COEF_WIDTH'((PROD_W'(lfsr) * PROD_W'(range_w)) >> LFSR_WIDTH);
        pick     = lo_q + offset;
        x_v      = x_q[var_q*COEF_WIDTH +: COEF_WIDTH];
    end

    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state        <= IDLE;
            out_busy     <= 1'b0;
            out_valid    <= 1'b0;
            out_feasible <= 1'b0;
            out_lower    <= '0;
            out_upper    <= '0;
            out_value    <= '0;
            out_error    <= 1'b0;
            clause_idx   <= '0;
            var_q        <= '0;
            x_q          <= '0;
            mask_q       <= '0;
            lo_q         <= '0;
            hi_q         <= '0;
            lfsr         <= (in_seed == '0) ? 16'h0001 : in_seed;
            for (int i = 0; i < NUM_CLAUSES; i++) bank[i] <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_load_valid) bank[in_load_index] <= in_load_coefficients;
                    if (in_start) begin
                        var_q      <= in_var_index;
                        x_q        <= in_assignment;
                        mask_q     <= in_clause_enable;
                        lo_q       <= LO_INIT;
                        hi_q       <= HI_INIT;
                        clause_idx <= '0;
                        out_busy   <= 1'b1;
                        state      <= REDUCE;
                    end
                end
                REDUCE: begin
                    if (is_lower && bound > lo_q) lo_q <= bound;
                    if (is_upper && bound < hi_q) hi_q <= bound;
                    if (clause_err) out_error <= 1'b1;
                    clause_idx <= clause_idx + CLAUSE_INDEX_WIDTH'(1);
                    if (&clause_idx) state <= SELECT;
                end
                SELECT: begin
                    out_feasible <= feasible;
                    out_lower    <= lo_q;
                    out_upper    <= hi_q;
                    out_value    <= feasible ? pick : x_v;
                    lfsr         <= lfsr_next(lfsr);
                    state        <= DONE;
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (in_ready) begin
                        out_valid <= 1'b0;
                        out_busy  <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PROPOSE_STATS_EN
    logic handshake;
    assign handshake = (state == DONE) && out_valid && in_ready;

    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            out_propose_count    <= '0;
            out_infeasible_count <= '0;
        end else if (handshake) begin
            if (out_propose_count != '1)
                out_propose_count <= out_propose_count + 16'd1;
            if (!out_feasible && out_infeasible_count != '1)
                out_infeasible_count <= out_infeasible_count + 16'd1;
        end
    end
`else
    assign out_propose_count    = '0;
    assign out_infeasible_count = '0;
`endif

endmodule

// File: tb/tb_propose_integer_bounded_seq.sv
// Directed bench for the sequential integer propose engine.
// Covers bounds, latency, backpressure, reset abort and error flag.
module tb_propose_integer_bounded_seq;

    logic        in_clk = 1'b0;
    logic        in_reset = 1'b1;
    logic [15:0] in_seed = 16'hACE1;
    logic        in_load_valid = 1'b0;
    logic [2:0]  in_load_index = '0;
    logic [39:0] in_load_coefficients = '0;
    logic        in_start = 1'b0;
    logic [1:0]  in_var_index = '0;
    logic [31:0] in_assignment = '0;
    logic [7:0]  in_clause_enable = '0;
    logic        in_ready = 1'b0;
    logic        out_busy;
    logic        out_valid;
    logic        out_feasible;
    logic [7:0]  out_lower;
    logic [7:0]  out_upper;
    logic [7:0]  out_value;
    logic        out_error;
    logic [15:0] out_propose_count;
    logic [15:0] out_infeasible_count;

    int tests = 0;
    int fails = 0;
    int exp_props = 0;
    int exp_infeas = 0;
    logic [15:0] ref_lfsr;

    propose_integer_bounded_seq dut (
        .in_clk               (in_clk),
        .in_reset             (in_reset),
        .in_seed              (in_seed),
        .in_load_valid        (in_load_valid),
        .in_load_index        (in_load_index),
        .in_load_coefficients (in_load_coefficients),
        .in_start             (in_start),
        .in_var_index         (in_var_index),
        .in_assignment        (in_assignment),
        .in_clause_enable     (in_clause_enable),
        .in_ready             (in_ready),
        .out_busy             (out_busy),
        .out_valid            (out_valid),
        .out_feasible         (out_feasible),
        .out_lower            (out_lower),
        .out_upper            (out_upper),
        .out_value            (out_value),
        .out_error            (out_error),
        .out_propose_count    (out_propose_count),
        .out_infeasible_count (out_infeasible_count)
    );

    always #5 in_clk = ~in_clk;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [15:0] ref_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic int ref_pick(input int lo, input int hi, input logic [15:0] s);
        return lo + ((int'(s) * (hi - lo + 1)) >>> 16);
    endfunction

    function automatic logic [39:0] clause(input int a0, input int a1,
                                           input int a2, input int a3,
                                           input int b);
        return {8'(b), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    function automatic logic [31:0] xvec(input int x0, input int x1,
                                         input int x2, input int x3);
        return {8'(x3), 8'(x2), 8'(x1), 8'(x0)};
    endfunction

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic load(input logic [2:0] idx, input logic [39:0] c);
        in_load_valid = 1'b1;
        in_load_index = idx;
        in_load_coefficients = c;
        tick();
        in_load_valid = 1'b0;
    endtask

    task automatic start(input logic [1:0] v, input logic [31:0] x, input logic [7:0] m);
        in_var_index = v;
        in_assignment = x;
        in_clause_enable = m;
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic handshake();
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
        exp_props++;
        if (!out_feasible) exp_infeas++;
    endtask

    task automatic test_reset();
        in_seed = 16'hACE1;
        in_reset = 1'b1;
        tick();
        tick();
        in_reset = 1'b0;
        ref_lfsr = 16'hACE1;
        tests++;
        if (out_busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl busy=%b valid=%b want 0 0", out_busy, out_valid);
        end
        tests++;
        if ({out_lower, out_upper, out_value, out_feasible, out_error} !== 26'd0) begin
            fails++;
            $display("FAIL reset_data lo=%h hi=%h val=%h f=%b e=%b want all 0",
                     out_lower, out_upper, out_value, out_feasible, out_error);
        end
        tests++;
        if (out_propose_count !== 16'd0 || out_infeasible_count !== 16'd0) begin
            fails++;
            $display("FAIL reset_counts p=%0d i=%0d want 0 0",
                     out_propose_count, out_infeasible_count);
        end
    endtask

    task automatic test_unconstrained();
        int lat;
        int ev;
        start(2'd1, xvec(1, 2, 3, 4), 8'h00);
        wait_valid(lat);
        tests++;
        if (lat !== 10) begin
            fails++;
            $display("FAIL latency got=%0d want 10", lat);
        end
        tests++;
        if (out_lower !== 8'h80 || out_upper !== 8'h7F || out_feasible !== 1'b1) begin
            fails++;
            $display("FAIL open_bounds lo=%h hi=%h f=%b want 80 7f 1",
                     out_lower, out_upper, out_feasible);
        end
        ev = ref_pick(-128, 127, ref_lfsr);
        tests++;
        if (out_value !== 8'(ev)) begin
            fails++;
            $display("FAIL open_value got=%0d want %0d", $signed(out_value), ev);
        end
        ref_lfsr = ref_step(ref_lfsr);
        handshake();
    endtask

    task automatic test_two_bounds();
        int lat;
        int ev;
        load(3'd0, clause(0, 1, 0, 0, -10));
        load(3'd1, clause(0, -1, 0, 0, 3));
        start(2'd1, xvec(0, 0, 0, 0), 8'h03);
        wait_valid(lat);
        ev = ref_pick(3, 10, ref_lfsr);
        tests++;
        if (out_lower !== 8'd3 || out_upper !== 8'd10 || out_feasible !== 1'b1) begin
            fails++;
            $display("FAIL two_bounds lo=%0d hi=%0d f=%b want 3 10 1",
                     $signed(out_lower), $signed(out_upper), out_feasible);
        end
        tests++;
        if (out_value !== 8'(ev)) begin
            fails++;
            $display("FAIL two_bounds_value got=%0d want %0d", $signed(out_value), ev);
        end
        ref_lfsr = ref_step(ref_lfsr);
        handshake();
    endtask

    task automatic test_point();
        int lat;
        load(3'd0, clause(1, 1, 2, 0, -20));
        load(3'd1, clause(0, -1, 0, 0, 10));
        start(2'd1, xvec(4, 0, 3, 0), 8'h03);
        wait_valid(lat);
        tests++;
        if (out_lower !== 8'd10 || out_upper !== 8'd10 || out_value !== 8'd10) begin
            fails++;
            $display("FAIL point lo=%0d hi=%0d val=%0d want 10 10 10",
                     $signed(out_lower), $signed(out_upper), $signed(out_value));
        end
        ref_lfsr = ref_step(ref_lfsr);
        handshake();
    endtask

    task automatic test_infeasible();
        int lat;
        load(3'd0, clause(0, 1, 0, 0, -2));
        load(3'd1, clause(0, -1, 0, 0, 5));
        start(2'd1, xvec(0, 7, 0, 0), 8'h03);
        wait_valid(lat);
        tests++;
        if (out_feasible !== 1'b0 || out_value !== 8'd7) begin
            fails++;
            $display("FAIL infeasible f=%b val=%0d want 0 7", out_feasible, $signed(out_value));
        end
        tests++;
        if (out_lower !== 8'd5 || out_upper !== 8'd2) begin
            fails++;
            $display("FAIL infeasible_bounds lo=%0d hi=%0d want 5 2",
                     $signed(out_lower), $signed(out_upper));
        end
        ref_lfsr = ref_step(ref_lfsr);
        handshake();
        tests++;
`ifdef PROPOSE_STATS_EN
        if (out_propose_count !== 16'(exp_props) || out_infeasible_count !== 16'(exp_infeas)) begin
            fails++;
            $display("FAIL stats p=%0d i=%0d want %0d %0d",
                     out_propose_count, out_infeasible_count, exp_props, exp_infeas);
        end
`else
        if (out_propose_count !== 16'd0 || out_infeasible_count !== 16'd0) begin
            fails++;
            $display("FAIL stats_off p=%0d i=%0d want 0 0",
                     out_propose_count, out_infeasible_count);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int lat;
        int ev;
        int bad;
        start(2'd2, xvec(9, 9, -5, 9), 8'h00);
        tick();
        load(3'd0, clause(0, 1, 0, 0, -100));
        wait_valid(lat);
        ev = ref_pick(-128, 127, ref_lfsr);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || out_busy !== 1'b1 ||
                out_value !== 8'(ev) || out_lower !== 8'h80) bad++;
            in_start = (i == 2);
            in_var_index = 2'd0;
            tick();
        end
        in_start = 1'b0;
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL backpressure_hold bad_cycles=%0d want 0 val=%0d exp=%0d",
                     bad, $signed(out_value), ev);
        end
        ref_lfsr = ref_step(ref_lfsr);
        handshake();
        tests++;
        if (out_busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL handshake_idle busy=%b valid=%b want 0 0", out_busy, out_valid);
        end
        tick();
        tests++;
        if (out_busy !== 1'b0) begin
            fails++;
            $display("FAIL restart_ignored busy=%b want 0", out_busy);
        end
    endtask

    task automatic test_load_ignored();
        int lat;
        int ev;
        start(2'd1, xvec(0, 0, 0, 0), 8'h01);
        wait_valid(lat);
        ev = ref_pick(-128, 2, ref_lfsr);
        tests++;
        if (out_lower !== 8'h80 || out_upper !== 8'd2 || out_value !== 8'(ev)) begin
            fails++;
            $display("FAIL load_busy lo=%0d hi=%0d val=%0d want -128 2 %0d",
                     $signed(out_lower), $signed(out_upper), $signed(out_value), ev);
        end
        ref_lfsr = ref_step(ref_lfsr);
        handshake();
    endtask

    task automatic test_reset_abort();
        int seen;
        start(2'd1, xvec(0, 0, 0, 0), 8'h00);
        tick();
        tick();
        in_seed = 16'h0000;
        in_reset = 1'b1;
        tick();
        in_reset = 1'b0;
        ref_lfsr = 16'h0001;
        exp_props = 0;
        exp_infeas = 0;
        tests++;
        if (out_busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL abort busy=%b valid=%b want 0 0", out_busy, out_valid);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid !== 1'b0 || out_busy !== 1'b0) seen++;
            tick();
        end
        tests++;
        if (seen !== 0 || out_propose_count !== 16'd0) begin
            fails++;
            $display("FAIL abort_quiet active_cycles=%0d p=%0d want 0 0",
                     seen, out_propose_count);
        end
    endtask

    task automatic test_error();
        int lat;
        int ev;
        load(3'd2, clause(0, 2, 0, 0, 50));
        load(3'd3, clause(0, -1, 0, 0, -20));
        start(2'd1, xvec(0, 0, 0, 0), 8'h0C);
        wait_valid(lat);
        ev = ref_pick(-20, 127, ref_lfsr);
        tests++;
        if (out_error !== 1'b1) begin
            fails++;
            $display("FAIL error_flag got=%b want 1", out_error);
        end
        tests++;
        if (out_lower !== 8'hEC || out_upper !== 8'h7F || out_value !== 8'(ev)) begin
            fails++;
            $display("FAIL error_bounds lo=%0d hi=%0d val=%0d want -20 127 %0d",
                     $signed(out_lower), $signed(out_upper), $signed(out_value), ev);
        end
        ref_lfsr = ref_step(ref_lfsr);
        handshake();
        tests++;
        if (out_error !== 1'b1) begin
            fails++;
            $display("FAIL error_sticky got=%b want 1", out_error);
        end
        in_reset = 1'b1;
        tick();
        in_reset = 1'b0;
        tests++;
        if (out_error !== 1'b0) begin
            fails++;
            $display("FAIL error_clear got=%b want 0", out_error);
        end
    endtask

    initial begin
        test_reset();
        test_unconstrained();
        test_two_bounds();
        test_point();
        test_infeasible();
        test_back_to_back();
        test_load_ignored();
        test_reset_abort();
        test_error();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
